hazard_ctrl: RTL

Pipeline sequencing controller for the five-stage RISC-V Lite core. It generates the enable and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers. It resolves load-use hazards, taken branches/jumps, data-memory wait states and a halt/drain request. It also counts stall cycles and flags a stuck memory access.

---
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: PC/IF-ID/ID-EX/EX-MEM enables and bubble flushes
// for load-use, taken branches, data-memory waits and halt/drain; tracks stall stats.
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  id_Rs1,
  input  logic [4:0]  id_Rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        ex_MemRead,
  input  logic [4:0]  ex_Rd,
  input  logic        ex_Rd_EQ0,
  input  logic        ex_take_branch,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        halt_req,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        halted,
  output logic        mem_err,
  output logic [15:0] stall_cnt
);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [DW-1:0] DONE = 1;
  localparam logic [WW-1:0] WONE = 1;

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

  state_t        state, state_next;
  logic [DW-1:0] drain_cnt;
  logic [WW-1:0] wait_cnt;
  logic          memstall, loaduse, freeze, drain_start;

  assign memstall = mem_req & ~mem_ready;
  assign loaduse  = ex_MemRead & ~ex_Rd_EQ0 &
                    ((id_uses_rs1 & (id_Rs1 == ex_Rd)) | (id_uses_rs2 & (id_Rs2 == ex_Rd)));
  // Once waiting, the access stays outstanding until mem_ready regardless of mem_req.
  assign freeze   = (state == MEM_WAIT) ? ~mem_ready : memstall;
  assign drain_start = (state == RUN || state == MEM_WAIT) && (state_next == DRAIN);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN, MEM_WAIT: begin
        if (freeze)                             state_next = MEM_WAIT;
        else if (ex_take_branch || loaduse)     state_next = RUN;
        else if (halt_req)                      state_next = DRAIN;
        else                                    state_next = RUN;
      end
      DRAIN:   if (!freeze && drain_cnt == '0) state_next = HALTED;
      HALTED:  if (!halt_req) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    halted      = 1'b0;
    if (rstn) begin
      case (state)
        RUN, MEM_WAIT: begin
          if (freeze) begin
            pc_en = 1'b0;
          end else if (ex_take_branch) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b1111;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (loaduse) begin
            {id_ex_en, ex_mem_en} = 2'b11;
            id_ex_flush = 1'b1;
          end else if (halt_req) begin
            {if_id_en, id_ex_en, ex_mem_en} = 3'b111;
            if_id_flush = 1'b1;
          end else begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b1111;
          end
        end
        DRAIN: begin
          // A branch resolving mid-drain still redirects the PC and squashes ID.
          if (!freeze) begin
            pc_en       = ex_take_branch;
            {if_id_en, id_ex_en, ex_mem_en} = 3'b111;
            if_id_flush = 1'b1;
            id_ex_flush = ex_take_branch;
          end
        end
        HALTED:  halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drain_cnt <= '0;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if ((state == RUN || state == MEM_WAIT) && !pc_en && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (drain_start)
        drain_cnt <= DW'(DRAIN_CYCLES - 1);
      else if (state == DRAIN && !freeze && drain_cnt != '0)
        drain_cnt <= drain_cnt - DONE;
      case (state)
        RUN: if (memstall) wait_cnt <= WW'(1);
        MEM_WAIT: begin
          if (mem_ready) begin
            wait_cnt <= '0;
          end else begin
            if (int'(wait_cnt) < MEM_TIMEOUT) wait_cnt <= wait_cnt + WONE;
            if (int'(wait_cnt) + 1 >= MEM_TIMEOUT) mem_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
